// File: rtl/regincr_stream_adapter.sv
// -----------------------------------------------------------------------------
// regincr_stream_adapter
//
// Latency-insensitive val/rdy wrapper around an external N-stage registered
// incrementer chain. Accepted messages are passed to the incrementer
// combinationally, and a valid bit travels through a shift register that
// matches the incrementer's latency. When that bit reaches the end of the
// shift register, the incrementer result is written into an output FIFO.
// Upstream flow control uses credits, so every result in flight already owns
// a FIFO slot and a stalled consumer cannot cause data loss.
//
// Parameters
//   p_nstages  latency of the attached incrementer chain in cycles (>=1)
//   p_depth    output FIFO entries and initial credit count (>=1, any value)
//
// Ports
//   clk       in   1     clock, rising edge
//   reset     in   1     asynchronous, active-low; clears all state
//   in_val    in   1     upstream message valid
//   in_rdy    out  1     adapter can accept a message (credits != 0)
//   in_msg    in   8     upstream message
//   incr_in   out  8     to incrementer input (equals in_msg)
//   incr_out  in   8     from incrementer output
//   out_val   out  1     FIFO head valid
//   out_rdy   in   1     downstream ready
//   out_msg   out  8     FIFO head data
//   credits   out  cw    free credits (debug / verification)
// -----------------------------------------------------------------------------
module regincr_stream_adapter #(
    parameter int p_nstages = 2,
    parameter int p_depth   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_val,
    output logic                         in_rdy,
    input  logic [7:0]                   in_msg,
    output logic [7:0]                   incr_in,
    input  logic [7:0]                   incr_out,
    output logic                         out_val,
    input  logic                         out_rdy,
    output logic [7:0]                   out_msg,
    output logic [$clog2(p_depth+1)-1:0] credits
);

    localparam int cw = $clog2(p_depth + 1);
    localparam int pw = (p_depth > 1) ? $clog2(p_depth) : 1;

    logic [p_nstages-1:0] vld;
    logic [pw-1:0]        wptr;
    logic [pw-1:0]        rptr;
    logic [cw-1:0]        count;
    logic [7:0]           mem [p_depth];

    logic accept;
    logic deq;
    logic enq;

    assign accept  = in_val & in_rdy;
    assign deq     = out_val & out_rdy;
    // The bit at the end of the valid pipe lines up with incr_out holding
    // that message's result.
    assign enq     = vld[p_nstages-1];

    // in_rdy depends on registered credits only: no out_rdy -> in_rdy path.
    assign in_rdy  = (credits != '0);
    assign out_val = (count != '0);
    assign out_msg = mem[rptr];
    assign incr_in = in_msg;

    // Valid pipe that shadows the incrementer stages.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement or block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= '0;
        end else begin
            vld <= (vld << 1) | p_nstages'(accept);
        end
    end

    // FIFO pointers, occupancy and credits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            credits <= cw'(p_depth);
        end else begin
            if (enq) begin
                wptr <= (wptr == pw'(p_depth - 1)) ? '0 : wptr + 1'b1;
            end
            if (deq) begin
                rptr <= (rptr == pw'(p_depth - 1)) ? '0 : rptr + 1'b1;
            end

            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case ({deq, accept})
                2'b10:   credits <= credits + 1'b1;
                2'b01:   credits <= credits - 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    // FIFO storage.
    // NOTE: the storage is reset here because out_msg must read 0 straight
    // out of reset. It is tiny, so clearing it costs little. A large RAM would
    // normally be left unreset and out_msg gated with out_val instead.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < p_depth; i++) begin
                mem[i] <= '0;
            end
        end else if (enq) begin
            mem[wptr] <= incr_out;
        end
    end

    // Every credit is either free, in flight in the incrementer, or buffered.
    // Because of this, an enqueue can never find the FIFO full.
    assert property (@(posedge clk) disable iff (!reset)
        !(enq && (count == cw'(p_depth)) && !deq))
        else $error("enqueue into full FIFO");

    assert property (@(posedge clk) disable iff (!reset)
        (int'(credits) + $countones(vld) + int'(count)) == p_depth)
        else $error("credit invariant broken");

endmodule
